video_timing_pattern_gen: RTL

Synthesizable, parametrised HDMI-style source that generates hs/vs/de timing and pixel data. It is the successor to the behavioural 640x480 bench streamer: timing is set by parameters, channel count and width are generic, and four runtime-selectable pattern modes are provided. It sits in front of the HDMI capture path, both as an on-chip test source and as a stimulus block in benches. It also exports frame and pixel indices so a checker can regenerate the expected data.

---
 rtl/vtpg_pkg.sv | 18 +
 rtl/video_timing_counter.sv | 60 ++++++
 rtl/video_timing_pattern_gen.sv | 121 ++++++++++++
 3 files changed

// File: rtl/vtpg_pkg.sv
// Shared types and LFSR step for the video timing/pattern generator and its checkers.
package vtpg_pkg;

    typedef enum logic [1:0] {
        VT_ZERO = 2'd0,
        VT_BARS = 2'd1,
        VT_RAMP = 2'd2,
        VT_LFSR = 2'd3
    } vt_mode_e;

    localparam logic [31:0] LFSR_TAPS = 32'h80200003;

    // Galois right shift: the bit shifted out selects whether the taps are folded back in.
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_TAPS : 32'h0);
    endfunction

endpackage

// File: rtl/video_timing_counter.sv
// Horizontal/vertical raster counters and the sync/active decode derived from them.
module video_timing_counter #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 20,
    parameter int H_SYNC   = 20,
    parameter int H_BP     = 20,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 30,
    parameter int HW       = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
    parameter int VW       = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    output logic [HW-1:0] hcnt,
    output logic [VW-1:0] vcnt,
    output logic          hs_int,
    output logic          vs_int,
    output logic          de_int,
    output logic          frame_end
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SYNC_S = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SYNC_E = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SYNC_S = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SYNC_E = VW'(V_ACTIVE + V_FP + V_SYNC);

    // Zero-width porches or syncs would collapse the region decode below.
    if (H_FP <= 0 || H_SYNC <= 0 || H_BP <= 0 || V_FP <= 0 || V_SYNC <= 0 || V_BP <= 0) begin : g_bad_timing
        $error("video_timing_counter: porch and sync widths must be non-zero");
    end

    always_ff @(posedge clk) begin
        if (!rst_n || !en) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (hcnt == H_LAST) begin
            hcnt <= '0;
            vcnt <= (vcnt == V_LAST) ? '0 : vcnt + VW'(1);
        end else begin
            hcnt <= hcnt + HW'(1);
        end
    end

    // vcnt only moves on the hcnt wrap, so vs_int can only change at hcnt==0.
    assign hs_int    = (hcnt >= H_SYNC_S) && (hcnt < H_SYNC_E);
    assign vs_int    = (vcnt >= V_SYNC_S) && (vcnt < V_SYNC_E);
    assign de_int    = (hcnt < H_ACT) && (vcnt < V_ACT);
    assign frame_end = (hcnt == H_LAST) && (vcnt == V_LAST);

endmodule

// File: rtl/video_timing_pattern_gen.sv
// Parametrised raster source: registered hs/vs/de plus selectable test patterns.
// de qualifies data, pix_x and pix_y; there is no back-pressure, the sink must accept every de=1 cycle.
module video_timing_pattern_gen
    import vtpg_pkg::*;
#(
    parameter int PIX_W     = 8,
    parameter int CHANNELS  = 3,
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 20,
    parameter int H_SYNC    = 20,
    parameter int H_BP      = 20,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 30,
    parameter int HS_POL    = 1,
    parameter int VS_POL    = 1,
    parameter int BAR_SHIFT = 6
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic [1:0]                    mode,
    input  logic [31:0]                   lfsr_seed,
    output logic                          hs,
    output logic                          vs,
    output logic                          de,
    output logic [PIX_W*CHANNELS-1:0]     data,
    output logic                          frame_start,
    output logic [$clog2(H_ACTIVE)-1:0]   pix_x,
    output logic [$clog2(V_ACTIVE)-1:0]   pix_y,
    output logic [15:0]                   frame_cnt
);

    localparam int DW = PIX_W * CHANNELS;
    localparam int HW = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam int VW = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP);
    localparam int XW = $clog2(H_ACTIVE);
    localparam int YW = $clog2(V_ACTIVE);
    localparam logic HS_ON = 1'(HS_POL);
    localparam logic VS_ON = 1'(VS_POL);

    if (DW > 32) begin : g_bad_width
        $error("video_timing_pattern_gen: PIX_W*CHANNELS must not exceed 32");
    end

    logic [HW-1:0] hcnt;
    logic [VW-1:0] vcnt;
    logic          hs_int, vs_int, de_int, frame_end;

    video_timing_counter #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .HW(HW), .VW(VW)
    ) u_counter (
        .clk(clk), .rst_n(rst_n), .en(en),
        .hcnt(hcnt), .vcnt(vcnt),
        .hs_int(hs_int), .vs_int(vs_int), .de_int(de_int), .frame_end(frame_end)
    );

    vt_mode_e         mode_q, mode_eff;
    logic [31:0]      lfsr_q, lfsr_cur, seed_eff;
    logic             fs_cond, en_d;
    logic [2:0]       bar;
    logic [PIX_W-1:0] ramp;
    logic [DW-1:0]    pix_data;

    // On the frame-start cycle the fresh mode and seed take effect for that very pixel.
    always_comb begin
        fs_cond  = (hcnt == '0) && (vcnt == '0);
        seed_eff = (lfsr_seed == 32'h0) ? 32'h1 : lfsr_seed;
        mode_eff = fs_cond ? vt_mode_e'(mode) : mode_q;
        lfsr_cur = fs_cond ? seed_eff : lfsr_q;
        bar      = 3'(hcnt >> BAR_SHIFT);
        ramp     = PIX_W'(32'(hcnt) + 32'(vcnt));
        pix_data = '0;
        case (mode_eff)
            VT_BARS: for (int c = 0; c < CHANNELS; c++) pix_data[c*PIX_W +: PIX_W] = {PIX_W{bar[c % 3]}};
            VT_RAMP: for (int c = 0; c < CHANNELS; c++) pix_data[c*PIX_W +: PIX_W] = ramp;
            VT_LFSR: pix_data = lfsr_cur[DW-1:0];
            default: pix_data = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n || !en) begin
            hs          <= ~HS_ON;
            vs          <= ~VS_ON;
            de          <= 1'b0;
            data        <= '0;
            frame_start <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            mode_q      <= VT_ZERO;
            lfsr_q      <= 32'h1;
        end else begin
            hs          <= hs_int ? HS_ON : ~HS_ON;
            vs          <= vs_int ? VS_ON : ~VS_ON;
            de          <= de_int;
            data        <= de_int ? pix_data : '0;
            frame_start <= fs_cond;
            pix_x       <= XW'(hcnt);
            pix_y       <= YW'(vcnt);
            if (fs_cond) mode_q <= mode_eff;
            lfsr_q      <= de_int ? lfsr_next(lfsr_cur) : lfsr_cur;
        end
    end

    // frame_cnt survives en=0 but restarts from zero on the first enabled cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_cnt <= 16'd0;
            en_d      <= 1'b0;
        end else begin
            en_d <= en;
            if (en && !en_d)        frame_cnt <= 16'd0;
            else if (en && frame_end) frame_cnt <= frame_cnt + 16'd1;
        end
    end

endmodule
